// File: rtl/ttt_game_engine.sv
// ---------------------------------------------------------------------------
// ttt_game_engine
//
// Tic-tac-toe game state machine feeding the VGA display stage. Owns the
// 3x3 board, alternates turns between X and O, and detects a win or a draw.
//
// Optional feature (compile-time macro TTT_TURN_TIMEOUT_EN):
//   When defined, each turn is limited to TURN_CYCLES clock cycles. On
//   expiry the lowest-indexed empty square receives the current mark and
//   'timeout' pulses for one cycle. When undefined there is no timer and
//   'timeout' stays low.
//
// Parameters:
//   TURN_CYCLES  per-turn time limit in clk cycles (timeout build only)
//   TIMER_W      width of the turn timer; must hold TURN_CYCLES
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   sel[3:0]            target square, 1..9 row-major (1 = top-left)
//   place               debounced button level; rising edge = place request
//   new_game            synchronous restart, active-high, highest priority
//   stateSq1..stateSq9  square contents: 0 empty, 1 X, 2 O
//   winner[2:0]         0 in progress, 1 X won, 2 O won, 3 draw
//   turn                0 = X to move, 1 = O to move
//   invalid_move        one-cycle pulse on a rejected place request
//   timeout             one-cycle pulse on an automatic placement
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ttt_game_engine #(
    parameter int unsigned TURN_CYCLES = 32'd500000000,
    parameter int unsigned TIMER_W     = 32'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       place,
    input  logic       new_game,
    output logic [2:0] stateSq1,
    output logic [2:0] stateSq2,
    output logic [2:0] stateSq3,
    output logic [2:0] stateSq4,
    output logic [2:0] stateSq5,
    output logic [2:0] stateSq6,
    output logic [2:0] stateSq7,
    output logic [2:0] stateSq8,
    output logic [2:0] stateSq9,
    output logic [2:0] winner,
    output logic       turn,
    output logic       invalid_move,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_TURN  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [2:0] MARK_EMPTY = 3'd0;
    localparam logic [2:0] MARK_X     = 3'd1;
    localparam logic [2:0] MARK_O     = 3'd2;
    localparam logic [2:0] RES_NONE   = 3'd0;
    localparam logic [2:0] RES_DRAW   = 3'd3;

    // Returns the mark owning a line of three, or empty if the line is open.
    function automatic logic [2:0] line_mark(input logic [2:0] a,
                                             input logic [2:0] b,
                                             input logic [2:0] c);
        logic [2:0] m;
        if ((a != MARK_EMPTY) && (a == b) && (b == c)) begin
            m = a;
        end else begin
            m = MARK_EMPTY;
        end
        return m;
    endfunction

    // First completed line among the 8 (rows, columns, diagonals).
    function automatic logic [2:0] find_winner(input logic [8:0][2:0] b);
        logic [2:0] w;
        w = line_mark(b[0], b[1], b[2]);
        if (w == MARK_EMPTY) w = line_mark(b[3], b[4], b[5]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[6], b[7], b[8]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[0], b[3], b[6]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[1], b[4], b[7]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[2], b[5], b[8]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[0], b[4], b[8]); else w = w;
        if (w == MARK_EMPTY) w = line_mark(b[2], b[4], b[6]); else w = w;
        return w;
    endfunction

    // True when no square is empty.
    function automatic logic board_full(input logic [8:0][2:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[i] == MARK_EMPTY) f = 1'b0; else f = f;
        end
        return f;
    endfunction

`ifdef TTT_TURN_TIMEOUT_EN
    // Index of the lowest-numbered empty square (0 if none, never used then).
    function automatic logic [3:0] first_empty(input logic [8:0][2:0] b);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!found && (b[i] == MARK_EMPTY)) begin
                idx   = 4'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

    localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES);

    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_nxt_s;
    logic [3:0]         empty_idx_s;
`endif

    state_t          state_r;
    state_t          state_nxt_s;
    logic [8:0][2:0] board_r;
    logic [8:0][2:0] board_nxt_s;
    logic [2:0]      winner_r;
    logic [2:0]      winner_nxt_s;
    logic            turn_r;
    logic            turn_nxt_s;
    logic            invalid_r;
    logic            invalid_nxt_s;
    logic            timeout_r;
    logic            timeout_nxt_s;
    logic            place_q_r;

    logic            req_s;
    logic            sel_ok_s;
    logic [3:0]      sel_idx_s;
    logic            sq_free_s;
    logic            valid_s;
    logic [2:0]      mark_s;
    logic [2:0]      line_win_s;
    logic            full_s;

    // Request decode: rising edge of place, square range and occupancy.
    always_comb begin
        req_s      = place & ~place_q_r;
        sel_ok_s   = (sel >= 4'd1) && (sel <= 4'd9);
        // Clamp the index so an out-of-range sel never addresses past square 9.
        sel_idx_s  = sel_ok_s ? (sel - 4'd1) : 4'd0;
        sq_free_s  = (board_r[sel_idx_s] == MARK_EMPTY);
        valid_s    = req_s & sel_ok_s & sq_free_s;
        mark_s     = turn_r ? MARK_O : MARK_X;
        line_win_s = find_winner(board_r);
        full_s     = board_full(board_r);
`ifdef TTT_TURN_TIMEOUT_EN
        empty_idx_s = first_empty(board_r);
`endif
    end

    // Next-state and next-datapath logic for the game FSM.
    always_comb begin
        state_nxt_s   = state_r;
        board_nxt_s   = board_r;
        winner_nxt_s  = winner_r;
        turn_nxt_s    = turn_r;
        invalid_nxt_s = 1'b0;
        timeout_nxt_s = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
        timer_nxt_s   = timer_r;
`endif
        if (new_game) begin
            // Restart wins over everything, including a same-cycle request.
            state_nxt_s  = ST_TURN;
            board_nxt_s  = '0;
            winner_nxt_s = RES_NONE;
            turn_nxt_s   = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
            timer_nxt_s  = TURN_LOAD;
`endif
        end else begin
            case (state_r)
                ST_TURN: begin
`ifdef TTT_TURN_TIMEOUT_EN
                    if (timer_r != '0) begin
                        timer_nxt_s = timer_r - TIMER_W'(1);
                    end else begin
                        timer_nxt_s = timer_r;
                    end
`endif
                    if (valid_s) begin
                        board_nxt_s[sel_idx_s] = mark_s;
                        state_nxt_s            = ST_CHECK;
                    end else begin
                        invalid_nxt_s = req_s;
`ifdef TTT_TURN_TIMEOUT_EN
                        // Expiry with no valid move: auto-place the mark.
                        if (timer_r == '0) begin
                            board_nxt_s[empty_idx_s] = mark_s;
                            timeout_nxt_s            = 1'b1;
                            state_nxt_s              = ST_CHECK;
                        end else begin
                            timeout_nxt_s            = 1'b0;
                        end
`endif
                    end
                end
                ST_CHECK: begin
                    // A completed line beats a full board.
                    if (line_win_s != MARK_EMPTY) begin
                        winner_nxt_s = line_win_s;
                        state_nxt_s  = ST_OVER;
                    end else if (full_s) begin
                        winner_nxt_s = RES_DRAW;
                        state_nxt_s  = ST_OVER;
                    end else begin
                        turn_nxt_s   = ~turn_r;
                        state_nxt_s  = ST_TURN;
`ifdef TTT_TURN_TIMEOUT_EN
                        timer_nxt_s  = TURN_LOAD;
`endif
                    end
                end
                ST_OVER: begin
                    state_nxt_s = ST_OVER;
                end
                default: begin
                    state_nxt_s = ST_TURN;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_TURN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Board, result, turn, pulse and edge-detect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_r   <= '0;
            winner_r  <= RES_NONE;
            turn_r    <= 1'b0;
            invalid_r <= 1'b0;
            timeout_r <= 1'b0;
            place_q_r <= 1'b0;
        end else begin
            board_r   <= board_nxt_s;
            winner_r  <= winner_nxt_s;
            turn_r    <= turn_nxt_s;
            invalid_r <= invalid_nxt_s;
            timeout_r <= timeout_nxt_s;
            place_q_r <= place;
        end
    end

`ifdef TTT_TURN_TIMEOUT_EN
    // Turn timer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= TURN_LOAD;
        end else begin
            timer_r <= timer_nxt_s;
        end
    end
`endif

    assign stateSq1     = board_r[0];
    assign stateSq2     = board_r[1];
    assign stateSq3     = board_r[2];
    assign stateSq4     = board_r[3];
    assign stateSq5     = board_r[4];
    assign stateSq6     = board_r[5];
    assign stateSq7     = board_r[6];
    assign stateSq8     = board_r[7];
    assign stateSq9     = board_r[8];
    assign winner       = winner_r;
    assign turn         = turn_r;
    assign invalid_move = invalid_r;
    assign timeout      = timeout_r;

endmodule

// File: doc/ttt_game_engine.md
Name: ttt_game_engine

Overview:
- Tic-tac-toe game state machine; sits directly upstream of the VGA display stage.
- Accepts debounced player inputs: square select plus place strobe.
- Owns the 3x3 board, alternates turns X/O, and detects win or draw.
- Drives the nine per-square state buses and the winner bus that the VGA stage renders.

Parameters:
- TURN_CYCLES, 500000000, per-turn time limit in clk cycles (10 s at 50 MHz); used only when the timeout feature is compiled in.
- TIMER_W, 32, width of the turn timer counter; must hold TURN_CYCLES.

Ports:
- clk  input  1  system clock (50 MHz board clock)
- rst  input  1  asynchronous, active-low reset
- sel  input  4  target square index, 1..9 row-major (1 = top-left, 9 = bottom-right)
- place  input  1  level from debounced button; rising edge = place request
- new_game  input  1  synchronous restart, active-high, level-sensitive
- stateSq1..stateSq9  output  3 each  square contents: 3'd0 empty, 3'd1 X, 3'd2 O; other codes never driven
- winner  output  3  3'd0 none/in progress, 3'd1 X won, 3'd2 O won, 3'd3 draw
- turn  output  1  0 = X to move, 1 = O to move
- invalid_move  output  1  one-cycle pulse on a rejected place request
- timeout  output  1  one-cycle pulse on an auto-placement due to turn expiry

Behaviour:
- Reset (rst low, async):
  - all stateSq = 0, winner = 0, turn = 0, invalid_move = 0, timeout = 0.
  - FSM = TURN; timer = TURN_CYCLES; place edge-detect register = 0.
- All outputs are registered; there is no combinational input-to-output path.
- Place edge: place_q holds place from the previous cycle; a request is place & ~place_q. A held button yields exactly one request.
- FSM states: TURN, CHECK, OVER.
- TURN, valid request (sel in 1..9 and square empty), at edge k:
  - square written with 1 (turn = 0) or 2 (turn = 1).
  - FSM -> CHECK.
  - stateSq visible after edge k.
- TURN, invalid request (sel = 0, sel > 9, or square occupied):
  - board unchanged, invalid_move = 1 for one cycle, FSM stays in TURN, timer keeps running.
- CHECK (exactly one cycle, edge k+1) evaluates the 8 lines (3 rows, 3 columns, 2 diagonals):
  - any line of three equal non-zero marks: winner = that mark, FSM -> OVER.
  - else all 9 squares non-zero: winner = 3 (draw), FSM -> OVER.
  - else: turn toggles, timer reloads to TURN_CYCLES, FSM -> TURN.
  - a win takes precedence over a draw when the board is full.
- Place requests arriving during CHECK are dropped silently: no invalid_move pulse.
- OVER:
  - board and winner frozen; place requests ignored with no invalid_move pulse.
  - exits only via new_game or reset.
- new_game (sampled at a clk edge, highest priority in every state):
  - clears the board, winner = 0, turn = 0, timer = TURN_CYCLES, FSM -> TURN.
  - a place request in the same cycle is discarded.
- Turn latency: place edge to stateSq update is 1 cycle; to winner/turn update is 2 cycles.
- Reset asserted mid-game: immediate clear per reset values, independent of clk.

Optional Feature:
- Macro: TTT_TURN_TIMEOUT_EN.
- Defined:
  - timer decrements by 1 each cycle while in TURN and holds in CHECK and OVER.
  - when timer = 0 in TURN and no valid request is present that cycle, the lowest-indexed empty square gets the current mark, timeout = 1 for one cycle, and FSM -> CHECK.
  - a valid player request in the same cycle as expiry wins; no timeout pulse is issued.
  - an invalid request coinciding with expiry gives both invalid_move = 1 and the auto-placement.
- Undefined:
  - no timer logic; timeout is tied to 0; turns never expire.

Test Plan:
- Reset, then X at 1, O at 4, X at 2, O at 5, X at 3 -> winner = 1 two cycles after the last edge; stateSq1..3 = 1, stateSq4..5 = 2; further place requests are ignored.
- Fill order 1X, 2O, 3X, 5O, 4X, 6O, 8X, 7O, 9X -> winner = 3, all squares non-zero, turn frozen.
- X at 5, then O at 5 -> invalid_move pulses once, stateSq5 stays 1, turn stays 1; then O at 0 and O at 10 -> two further pulses, board unchanged.
- Hold place high for 100 cycles with sel = 7 -> only stateSq7 = 1 is written, turn = 1, no invalid_move pulse.
- Mid-game, pulse new_game together with a place request -> all squares 0, winner = 0, turn = 0, place discarded; then assert rst low asynchronously between clk edges -> outputs clear immediately.
- With TTT_TURN_TIMEOUT_EN and TURN_CYCLES = 20, squares 1-2 occupied, no input -> after 20 cycles in TURN, square 3 gets the current mark, timeout pulses once, and turn toggles one cycle later.
